pe_dma_mem_requester: RTL
=========================

// Module: pe_dma_mem_requester
// PURPOSE
//  PE-side DMA initiator for the DMA<->memory-controller port. Turns one command (addr, len, dir) into
//  per-word write or read requests to mem_acc_cont, buffers returned read data, and streams it out.
//  Sits between the PE streaming-op datapath and mem_acc_cont; drives every dma__memc__* signal.
// PARAMETERS
//  ADDR_W     24  word address width (matches MEM_ACC_CONT_MEMORY_ADDRESS_RANGE)
//  DATA_W     64  memory word width (matches MEM_ACC_CONT_MEMORY_DATA_RANGE)
//  LEN_W      16  command length field width, in words
//  RD_DEPTH    8  read-return FIFO entries (power of 2, >=4)
//  PAUSE_TH    2  assert read_pause when FIFO free entries <= PAUSE_TH
// PORTS
//  clk                         in   1       clock
//  reset                       in   1       synchronous, active-high reset
//  cmd_valid/cmd_ready         in/out 1     command handshake
//  cmd_write                   in   1       1=write from in_*, 0=read to out_*
//  cmd_addr / cmd_len          in   ADDR_W/LEN_W  start word address / word count (0 = no-op)
//  in_valid/in_ready           in/out 1     write-data stream; in_data in DATA_W
//  out_valid/out_ready         out/in 1     read-data stream; out_data out DATA_W
//  done                        out  1       1-cycle pulse at command completion
//  dma__memc__write_valid/_address/_data   out 1/ADDR_W/DATA_W
//  memc__dma__write_ready      in   1
//  dma__memc__read_valid/_address          out 1/ADDR_W
//  memc__dma__read_ready       in   1
//  memc__dma__read_data/_data_valid        in DATA_W/1
//  dma__memc__read_pause       out  1
// BEHAVIOUR
//  - Reset: all outputs 0, cmd_ready=0 in reset cycle then 1 in IDLE; FIFO empty; counters 0. Reset
//    mid-command aborts it: no done, in-flight read data after reset is dropped (outstanding cleared).
//  - FSM: IDLE -> WR (cmd_write) | RD (!cmd_write) on cmd_valid&cmd_ready; len==0 -> DONE directly.
//    WR -> DONE when last write accepted. RD -> RD_DRAIN when last request accepted;
//    RD_DRAIN -> DONE when outstanding==0 and FIFO empty. DONE: done=1 one cycle -> IDLE.
//  - cmd_ready=1 only in IDLE; cmd fields captured on acceptance.
//  - Write: write_valid = in_valid in WR; in_ready = write_ready in WR; word transfers when
//    write_valid&write_ready; address = cmd_addr + count, zero latency, no buffering.
//  - Read request: read_valid in RD when outstanding + fifo_count < RD_DEPTH (credit);
//    accepted on read_valid&read_ready; address increments per accept.
//  - Return: every read_data_valid cycle is pushed, pause or not (credits guarantee space);
//    outstanding decrements per return; simultaneous accept+return leaves outstanding unchanged.
//  - read_pause = registered (free <= PAUSE_TH); advisory only, never a correctness dependency.
//  - Out: out_valid = FIFO not empty; pop on out_valid&out_ready; push+pop same cycle at full OK.
//  - Address arithmetic modulo 2^ADDR_W (wraps silently at top). Data returned strictly in order.
//  - Latency: first write request combinational on in_valid cycle after accept; first read req 1 cycle
//    after cmd accept; FIFO read-out 1 cycle after push.
// CONFIGURATION
//  PE_DMA_MEM_REQ_PERF_CNT_EN: adds outputs rd_stall_cnt[31:0] (cycles read_valid&!read_ready) and
//  out_stall_cnt[31:0] (cycles out_valid&!out_ready), cleared at reset and on cmd accept, saturate.
//  Without it: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package pe_dma_mem_req_pkg: state enum {IDLE,WR,RD,RD_DRAIN,DONE}, ADDR_W/DATA_W/LEN_W defaults,
//  command struct {write,addr,len}. Sub-module pe_dma_rd_fifo (sync FIFO, count/free outputs).
// TESTING
//  1. Write addr=0x10 len=4, write_ready toggling 1,0,1 -> 4 writes at 0x10..0x13, done after 4th.
//  2. Read addr=0x100 len=8, memc 3-cycle latency, out_ready=1 -> data of 0x100..0x107 in order, done.
//  3. Read len=16, out_ready=0 -> requests stop with outstanding+count=8, read_pause=1 once free<=2;
//     release out_ready -> all 16 words out, no loss/dup.
//  4. Read addr=0xFFFFFE len=4 -> addresses FFFFFE,FFFFFF,000000,000001.
//  5. cmd len=0 -> done 1 cycle after accept, no memc traffic; reset during RD with 3 outstanding ->
//     outputs 0, no done, late returns ignored, next command correct.

Source files
------------

// File: rtl/pe_dma_mem_req_pkg.sv
// Shared types and default widths for the PE-side DMA memory requester.
package pe_dma_mem_req_pkg;

  localparam int PKG_ADDR_W = 24;
  localparam int PKG_DATA_W = 64;
  localparam int PKG_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/pe_dma_rd_fifo.sv
// Synchronous read-return FIFO; DEPTH must be a power of two. Push while full is
// accepted only when a pop happens in the same cycle.
module pe_dma_rd_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign free_o     = DEPTH_C - count_q;

endmodule

// File: rtl/pe_dma_mem_requester.sv
// PE-side DMA initiator: turns one (addr, len, dir) command into per-word memc requests.
// Optional stall counters are built when PE_DMA_MEM_REQ_PERF_CNT_EN is defined.
module pe_dma_mem_requester
  import pe_dma_mem_req_pkg::*;
#(
  parameter int ADDR_W   = PKG_ADDR_W,
  parameter int DATA_W   = PKG_DATA_W,
  parameter int LEN_W    = PKG_LEN_W,
  parameter int RD_DEPTH = 8,
  parameter int PAUSE_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              dma__memc__write_valid,
  output logic [ADDR_W-1:0] dma__memc__write_address,
  output logic [DATA_W-1:0] dma__memc__write_data,
  input  logic              memc__dma__write_ready,
  output logic              dma__memc__read_valid,
  output logic [ADDR_W-1:0] dma__memc__read_address,
  input  logic              memc__dma__read_ready,
  input  logic [DATA_W-1:0] memc__dma__read_data,
  input  logic              memc__dma__read_data_valid,
  output logic              dma__memc__read_pause
`ifdef PE_DMA_MEM_REQ_PERF_CNT_EN
  ,
  output logic [31:0]       rd_stall_cnt,
  output logic [31:0]       out_stall_cnt
`endif
);

  localparam int CW = $clog2(RD_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_DEPTH);
  localparam logic [CW-1:0] PAUSE_C = CW'(PAUSE_TH);

  state_e            state_q;
  logic              cmd_ready_q, done_q, pause_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [CW-1:0]     outst_q;
  logic              cmd_acc, wr_acc, rd_acc, last_word;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count, fifo_free;
  logic [CW:0]       credit_used;
  logic [DATA_W-1:0] fifo_rdata;

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign cmd_acc   = cmd_valid & cmd_ready_q;
  assign last_word = (rem_q == LEN_W'(1));

  assign dma__memc__write_valid   = (state_q == WR) & in_valid;
  assign in_ready                 = (state_q == WR) & memc__dma__write_ready;
  assign dma__memc__write_address = (state_q == WR) ? addr_q : '0;
  assign dma__memc__write_data    = (state_q == WR) ? in_data : '0;
  assign wr_acc                   = dma__memc__write_valid & memc__dma__write_ready;

  // A request is only issued when its return is guaranteed a FIFO slot.
  assign credit_used             = {1'b0, outst_q} + {1'b0, fifo_count};
  assign dma__memc__read_valid   = (state_q == RD) & (credit_used < {1'b0, DEPTH_C});
  assign dma__memc__read_address = (state_q == RD) ? addr_q : '0;
  assign rd_acc                  = dma__memc__read_valid & memc__dma__read_ready;
  assign dma__memc__read_pause   = pause_q;

  // Returns with nothing outstanding belong to an aborted command and are dropped.
  assign fifo_push = memc__dma__read_data_valid & (outst_q != '0);
  assign out_valid = ~fifo_empty;
  assign fifo_pop  = out_valid & out_ready;
  assign out_data  = fifo_rdata;

  // Command FSM with registered cmd_ready/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_acc) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            rem_q       <= cmd_len;
            if (cmd_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= cmd_write ? WR : RD;
            end
          end
        end
        WR: begin
          if (wr_acc) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - LEN_W'(1);
            if (last_word) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_acc) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - LEN_W'(1);
            if (last_word) state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if ((outst_q == '0) && fifo_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-read tracking and advisory pause
  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= '0;
      pause_q <= 1'b0;
    end else begin
      case ({rd_acc, fifo_push})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
      pause_q <= (fifo_free <= PAUSE_C);
    end
  end

  pe_dma_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_DEPTH)
  ) u_rd_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (memc__dma__read_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .free_o      (fifo_free)
  );

`ifdef PE_DMA_MEM_REQ_PERF_CNT_EN
  logic [31:0] rd_stall_q, out_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || cmd_acc) begin
      rd_stall_q  <= '0;
      out_stall_q <= '0;
    end else begin
      if (dma__memc__read_valid && !memc__dma__read_ready) rd_stall_q <= sat_inc(rd_stall_q);
      if (out_valid && !out_ready) out_stall_q <= sat_inc(out_stall_q);
    end
  end

  assign rd_stall_cnt  = rd_stall_q;
  assign out_stall_cnt = out_stall_q;
`endif

endmodule
